// File: rtl/md5_guess_generator.sv
// Brute-force candidate source: enumerates every string over [CHAR_MIN, CHAR_MAX] for lengths start_len+1..end_len+1.
// Latency: first guess 1 cycle after start; one guess per en cycle; registered outputs; en=0 holds the guess.
module md5_guess_generator #(
    parameter logic [7:0] CHAR_MIN = 8'h61,
    parameter logic [7:0] CHAR_MAX = 8'h7A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [3:0]   start_len,
    input  logic [3:0]   end_len,
    input  logic         en,
    output logic [127:0] guess,
    output logic [3:0]   guesslen,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic [31:0]  count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [127:0]   guess_q;
    logic [3:0]     guesslen_q;
    logic [3:0]     start_len_q;
    logic [3:0]     end_len_q;
    logic [31:0]    count_q;
    logic           valid_q;
    logic           busy_q;
    logic           done_q;

    logic [127:0]   step_guess_d;
    logic           all_max_d;

    // Bytes 0..len set to CHAR_MIN, the rest zero.
    function automatic logic [127:0] fill_min(input logic [3:0] len);
        logic [127:0] g;
        g = '0;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) <= len) g[127-8*i -: 8] = CHAR_MIN;
        end
        return g;
    endfunction

    // Odometer step: byte at index guesslen is least significant.
    always_comb begin
        logic carry;
        step_guess_d = guess_q;
        all_max_d    = 1'b1;
        carry        = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (4'(i) <= guesslen_q) begin
                if (guess_q[127-8*i -: 8] != CHAR_MAX) all_max_d = 1'b0;
                if (carry) begin
                    if (guess_q[127-8*i -: 8] == CHAR_MAX) begin
                        step_guess_d[127-8*i -: 8] = CHAR_MIN;
                    end else begin
                        step_guess_d[127-8*i -: 8] = guess_q[127-8*i -: 8] + 8'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            guess_q     <= '0;
            guesslen_q  <= '0;
            start_len_q <= '0;
            end_len_q   <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        start_len_q <= start_len;
                        end_len_q   <= end_len;
                        count_q     <= '0;
                        if (start_len > end_len) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            guesslen_q <= start_len;
                            guess_q    <= fill_min(start_len);
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // stop outranks a same-cycle consume, so count excludes that guess
                    if (stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (en) begin
                        count_q <= count_q + 32'd1;
                        if (!all_max_d) begin
                            guess_q <= step_guess_d;
                        end else if (guesslen_q < end_len_q) begin
                            guesslen_q <= guesslen_q + 4'd1;
                            guess_q    <= fill_min(guesslen_q + 4'd1);
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign guess    = guess_q;
    assign guesslen = guesslen_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_md5_guess_generator.sv
// Bench for md5_guess_generator: expected guesses are queued at start, a negedge monitor checks each consumed guess.
module tb_md5_guess_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic [3:0]   start_len;
    logic [3:0]   end_len;
    logic         en;
    logic [127:0] guess;
    logic [3:0]   guesslen;
    logic         valid;
    logic         busy;
    logic         done;
    logic [31:0]  count;

    always #5 clk = ~clk;

    md5_guess_generator dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .start_len (start_len),
        .end_len   (end_len),
        .en        (en),
        .guess     (guess),
        .guesslen  (guesslen),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    typedef struct {
        logic [127:0] g;
        logic [3:0]   l;
        logic [31:0]  c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Guess number k among all strings of L chars, written as base-26 digits over 'a'..'z'.
    function automatic logic [127:0] exp_guess(input int L, input int k);
        logic [127:0] g;
        int rem;
        g   = '0;
        rem = k;
        for (int j = L - 1; j >= 0; j--) begin
            g[127-8*j -: 8] = 8'h61 + 8'(rem % 26);
            rem = rem / 26;
        end
        return g;
    endfunction

    task automatic push_run(input int lo, input int hi);
        int c;
        int n;
        c = 0;
        for (int L = lo + 1; L <= hi + 1; L++) begin
            n = 1;
            for (int p = 0; p < L; p++) n = n * 26;
            for (int k = 0; k < n; k++) begin
                exp_t e;
                e.g = exp_guess(L, k);
                e.l = 4'(L - 1);
                e.c = 32'(c);
                sb.push_back(e);
                c++;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid) chk("valid_implies_busy", 128'(busy), 128'd1);
        if (!reset && valid && en && !stop) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_consume actual guess=%h required=no live guess", guess);
            end else begin
                e = sb.pop_front();
                chk("sb_guess", guess, e.g);
                chk("sb_guesslen", 128'(guesslen), 128'(e.l));
                chk("sb_count", 128'(count), 128'(e.c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] lo, input logic [3:0] hi);
        start_len = lo;
        end_len   = hi;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk(name, 128'(done), 128'd1);
    endtask

    task automatic wait_count(input string name, input int target, input int max);
        int n;
        n = 0;
        while (count != 32'(target) && n < max) begin
            tick();
            n++;
        end
        chk(name, 128'(count), 128'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_guess"}, guess, 128'd0);
        chk({tag, "_guesslen"}, 128'(guesslen), 128'd0);
        chk({tag, "_valid"}, 128'(valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_count"}, 128'(count), 128'd0);
    endtask

    initial begin
        logic [3:0]   pat;
        logic [31:0]  held_c;
        logic [127:0] held_g;
        int           n;

        reset = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
        start_len = 4'd0; end_len = 4'd0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // single letters a..z
        en = 1'b1;
        push_run(0, 0);
        do_start(4'd0, 4'd0);
        chk("t1_first_guess", guess, 128'h61000000_00000000_00000000_00000000);
        chk("t1_first_valid", 128'(valid), 128'd1);
        chk("t1_first_busy", 128'(busy), 128'd1);
        chk("t1_first_len", 128'(guesslen), 128'd0);
        wait_done("t1_done", 40);
        chk("t1_count", 128'(count), 128'd26);
        chk("t1_valid_after", 128'(valid), 128'd0);
        chk("t1_busy_after", 128'(busy), 128'd0);
        chk("t1_last_guess", guess, 128'h7A000000_00000000_00000000_00000000);
        chk("t1_sb_empty", 128'(sb.size()), 128'd0);

        // lengths 1..2 with length transition and carry
        push_run(0, 1);
        do_start(4'd0, 4'd1);
        n = 0;
        while (!done && n < 800) begin
            if (count == 32'd26) begin
                chk("t2_aa", guess, 128'h61610000_00000000_00000000_00000000);
                chk("t2_aa_len", 128'(guesslen), 128'd1);
            end
            if (count == 32'd51) chk("t2_az", guess, 128'h617A0000_00000000_00000000_00000000);
            if (count == 32'd52) chk("t2_ba", guess, 128'h62610000_00000000_00000000_00000000);
            tick();
            n++;
        end
        chk("t2_done", 128'(done), 128'd1);
        chk("t2_count", 128'(count), 128'd702);
        chk("t2_last_guess", guess, 128'h7A7A0000_00000000_00000000_00000000);
        chk("t2_sb_empty", 128'(sb.size()), 128'd0);

        // en pattern 1,0,0,1
        pat = 4'b1001;
        push_run(0, 0);
        do_start(4'd0, 4'd0);
        n = 0;
        while (!done && n < 200) begin
            en = pat[n % 4];
            held_c = count;
            held_g = guess;
            tick();
            if (!pat[n % 4]) begin
                chk("t3_hold_count", 128'(count), 128'(held_c));
                chk("t3_hold_guess", guess, held_g);
                chk("t3_hold_valid", 128'(valid), 128'd1);
            end
            n++;
        end
        en = 1'b1;
        chk("t3_done", 128'(done), 128'd1);
        chk("t3_count", 128'(count), 128'd26);
        chk("t3_sb_empty", 128'(sb.size()), 128'd0);

        // stop with same-cycle en at count 10
        push_run(0, 1);
        do_start(4'd0, 4'd1);
        wait_count("t4_reach10", 10, 50);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_valid", 128'(valid), 128'd0);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_done", 128'(done), 128'd0);
        chk("t4_count", 128'(count), 128'd10);
        sb.delete();
        push_run(0, 0);
        do_start(4'd0, 4'd0);
        chk("t4_restart_guess", guess, 128'h61000000_00000000_00000000_00000000);
        chk("t4_restart_count", 128'(count), 128'd0);
        wait_done("t4_restart_done", 40);
        chk("t4_restart_final", 128'(count), 128'd26);

        // start_len > end_len
        do_start(4'd3, 4'd2);
        chk("t5_done", 128'(done), 128'd1);
        chk("t5_count", 128'(count), 128'd0);
        chk("t5_busy", 128'(busy), 128'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_valid", 128'(valid), 128'd0);
            tick();
        end

        // reset mid-run with start held during reset
        push_run(0, 0);
        do_start(4'd0, 4'd0);
        wait_count("t6_reach5", 5, 20);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk_all_zero("t6_reset");
        sb.delete();
        tick();
        chk("t6_idle_valid", 128'(valid), 128'd0);
        chk("t6_idle_busy", 128'(busy), 128'd0);
        chk("t6_idle_done", 128'(done), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
